wb_bkram_responder: RTL and testbench
=====================================

WB_BKRAM_RESPONDER -- requirements
Module: wb_bkram_responder

Interface
REQ-001 Parameter ADDRESS_WIDTH, default 30, is the Wishbone word-address width (AW).
REQ-002 Parameter DW, default 32, is the data width; byte-select width is DW/8.
REQ-003 Parameter LGMEMSZ, default 12, gives a memory depth of 2^LGMEMSZ words.
REQ-004 Parameter BKRAM_ADDR [AW-1:0], default 30'h4000000, is the base of the decoded window.
REQ-005 Parameter BKRAM_MASK [AW-1:0], default 30'h4000000, is the decode mask for the window.
REQ-006 Parameter EXTRA_LATENCY, default 0, adds one response-pipeline stage when set to 1.
REQ-007 i_clk  input  1  sole clock; all state updates on the rising edge.
REQ-008 i_reset_n  input  1  asynchronous, active-low reset.
REQ-009 i_wb_cyc  input  1  bus cycle active.
REQ-010 i_wb_stb  input  1  request strobe.
REQ-011 i_wb_we  input  1  1 = write, 0 = read.
REQ-012 i_wb_addr  input  AW  word address.
REQ-013 i_wb_data  input  DW  write data.
REQ-014 i_wb_sel  input  DW/8  byte-lane enables.
REQ-015 o_wb_stall  output  1  request not accepted this cycle.
REQ-016 o_wb_ack  output  1  successful completion.
REQ-017 o_wb_data  output  DW  read data.
REQ-018 o_wb_err  output  1  error completion.

Function
REQ-019 o_wb_stall SHALL be constant 0; a request is accepted on any cycle with i_wb_cyc && i_wb_stb.
REQ-020 A request is in-window when (i_wb_addr & BKRAM_MASK) == BKRAM_ADDR; the memory index is i_wb_addr[LGMEMSZ-1:0].
REQ-021 An accepted in-window write SHALL update exactly the byte lanes with i_wb_sel set; other lanes keep prior contents.
REQ-022 An accepted in-window read SHALL return the addressed word on o_wb_data in the same cycle o_wb_ack asserts.
REQ-023 With EXTRA_LATENCY=0, o_wb_ack/o_wb_err SHALL assert exactly 1 cycle after acceptance; with EXTRA_LATENCY=1, exactly 2 cycles after.
REQ-024 Back-to-back requests SHALL produce back-to-back responses in order, one response per accepted request, full throughput.
REQ-025 A read accepted the cycle after a write to the same index SHALL return the newly written data.
REQ-026 An out-of-window request SHALL not modify memory and SHALL assert o_wb_err, not o_wb_ack, with the latency of REQ-023.
REQ-027 o_wb_ack and o_wb_err SHALL never be high in the same cycle.
REQ-028 Deasserting i_wb_cyc SHALL clear all in-flight responses; no ack/err asserts on the cycle after cyc is low unless a new request is accepted.
REQ-029 A write accepted in the same cycle i_wb_cyc later drops SHALL still commit to memory.
REQ-030 o_wb_data SHALL hold its last read value across write acks, errors and idle cycles.
REQ-031 When i_wb_cyc is low, i_wb_stb SHALL be ignored.

Reset
REQ-032 While i_reset_n is low: o_wb_ack=0, o_wb_err=0, o_wb_data=0, response pipeline empty, applied asynchronously.
REQ-033 Memory contents SHALL not be cleared by reset; writes SHALL not occur while reset is asserted.
REQ-034 Reset asserted mid-transaction SHALL discard all pending responses; none appear after release.
REQ-035 Responses resume normally starting with the first request accepted after i_reset_n returns high.

Verification
REQ-036 Write addr 30'h4000010, data 32'hDEADBEEF, sel 4'hF, then read it -> ack 1 cycle after each, read data 32'hDEADBEEF.
REQ-037 Write 32'h11223344 sel 4'hF, then 32'hAABBCCDD sel 4'b0101, then read -> data 32'h11BB33DD.
REQ-038 Four consecutive reads, stb held high 4 cycles, EXTRA_LATENCY=1 -> four consecutive acks starting 2 cycles after first stb, correct data in order.
REQ-039 Read addr 30'h0000010 (outside window) -> o_wb_err 1 cycle later, o_wb_ack stays 0, o_wb_data unchanged.
REQ-040 Issue read, drop i_wb_cyc next cycle (EXTRA_LATENCY=1) -> no ack or err ever asserts.
REQ-041 Pull i_reset_n low with 2 reads in flight -> ack/err/data go to 0 immediately; no ack after release until a new request.

Source files
------------

// File: rtl/wb_bkram_if.sv
// ----------------------------------------------------------------------------
// wb_bkram_if
//
// Pipelined Wishbone (B4) slave-side bundle used by wb_bkram_responder.
// The i_/o_ prefixes are named from the responder's point of view.
//
// Parameters
//   AW : word-address width
//   DW : data width (byte-select width is DW/8)
//
// Signals
//   i_wb_cyc   : bus cycle active
//   i_wb_stb   : request strobe
//   i_wb_we    : 1 = write, 0 = read
//   i_wb_addr  : word address
//   i_wb_data  : write data
//   i_wb_sel   : byte-lane enables
//   o_wb_stall : request not accepted this cycle
//   o_wb_ack   : successful completion
//   o_wb_data  : read data
//   o_wb_err   : error completion
// ----------------------------------------------------------------------------
interface wb_bkram_if #(
  parameter int AW = 30,
  parameter int DW = 32
);

  logic            i_wb_cyc;
  logic            i_wb_stb;
  logic            i_wb_we;
  logic [AW-1:0]   i_wb_addr;
  logic [DW-1:0]   i_wb_data;
  logic [DW/8-1:0] i_wb_sel;
  logic            o_wb_stall;
  logic            o_wb_ack;
  logic [DW-1:0]   o_wb_data;
  logic            o_wb_err;

  modport master (
    output i_wb_cyc,
    output i_wb_stb,
    output i_wb_we,
    output i_wb_addr,
    output i_wb_data,
    output i_wb_sel,
    input  o_wb_stall,
    input  o_wb_ack,
    input  o_wb_data,
    input  o_wb_err
  );

  modport slave (
    input  i_wb_cyc,
    input  i_wb_stb,
    input  i_wb_we,
    input  i_wb_addr,
    input  i_wb_data,
    input  i_wb_sel,
    output o_wb_stall,
    output o_wb_ack,
    output o_wb_data,
    output o_wb_err
  );

endinterface

// File: rtl/wb_bkram_responder.sv
// ----------------------------------------------------------------------------
// wb_bkram_responder
//
// Block-RAM backed pipelined Wishbone slave. Never stalls: every cycle with
// cyc && stb is a request. Requests whose address falls inside the decoded
// window (addr & BKRAM_MASK) == BKRAM_ADDR access a 2^LGMEMSZ-word memory
// indexed by the low address bits; all others complete with err and leave
// memory untouched. Responses come 1 cycle after acceptance, or 2 cycles
// with EXTRA_LATENCY=1, in order at full throughput.
//
// Parameters
//   ADDRESS_WIDTH : Wishbone word-address width
//   DW            : data width
//   LGMEMSZ       : log2 of memory depth in words
//   BKRAM_ADDR    : base of the decoded window
//   BKRAM_MASK    : decode mask for the window
//   EXTRA_LATENCY : 0 or 1, adds one response stage when 1
//
// Ports
//   i_clk     : clock, rising edge
//   i_reset_n : asynchronous active-low reset (memory is not cleared)
//   wb        : slave side of the Wishbone bundle (wb_bkram_if.slave)
// ----------------------------------------------------------------------------
module wb_bkram_responder #(
  parameter int                       ADDRESS_WIDTH = 30,
  parameter int                       DW            = 32,
  parameter int                       LGMEMSZ       = 12,
  parameter logic [ADDRESS_WIDTH-1:0] BKRAM_ADDR    = 30'h4000000,
  parameter logic [ADDRESS_WIDTH-1:0] BKRAM_MASK    = 30'h4000000,
  parameter int                       EXTRA_LATENCY = 0
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  wb_bkram_if.slave  wb
);

  localparam int NB    = DW / 8;
  localparam int DEPTH = 1 << LGMEMSZ;

  function automatic logic in_window(input logic [ADDRESS_WIDTH-1:0] a);
    return (a & BKRAM_MASK) == BKRAM_ADDR;
  endfunction

  logic [DW-1:0] mem [0:DEPTH-1];

  logic               req_p0;
  logic               hit_p0;
  logic               miss_p0;
  logic               wr_p0;
  logic               rd_p0;
  logic [LGMEMSZ-1:0] idx_p0;

  logic               ack_q;
  logic               err_q;
  logic [DW-1:0]      data_q;

  // ---- stage p0: request decode (accepted combinationally, never stalled) --
  // Reset gates acceptance so no write can land in memory while held.
  assign req_p0  = wb.i_wb_cyc & wb.i_wb_stb & i_reset_n;
  assign hit_p0  = req_p0 &  in_window(wb.i_wb_addr);
  assign miss_p0 = req_p0 & ~in_window(wb.i_wb_addr);
  assign wr_p0   = hit_p0 &  wb.i_wb_we;
  assign rd_p0   = hit_p0 & ~wb.i_wb_we;
  assign idx_p0  = wb.i_wb_addr[LGMEMSZ-1:0];

  // Memory array has no reset so contents survive i_reset_n. A write commits
  // on its acceptance edge regardless of what cyc does afterwards, and a read
  // accepted on the next cycle sees it.
  always_ff @(posedge i_clk) begin
    if (wr_p0) begin
      for (int b = 0; b < NB; b++) begin
        if (wb.i_wb_sel[b])
          mem[idx_p0][b*8 +: 8] <= wb.i_wb_data[b*8 +: 8];
      end
    end
  end

  generate
    if (EXTRA_LATENCY == 0) begin : g_lat1

      // ---- stage p1: response registers ----------------------------------
      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          ack_q  <= 1'b0;
          err_q  <= 1'b0;
          data_q <= '0;
        end else begin
          ack_q <= hit_p0;
          err_q <= miss_p0;
          // Read data only moves on in-window reads; it holds across
          // write acks, errors and idle cycles.
          if (rd_p0)
            data_q <= mem[idx_p0];
        end
      end

    end else begin : g_lat2

      logic          vld_p1;
      logic          err_p1;
      logic          rd_p1;
      logic [DW-1:0] data_p1;

      // ---- stage p1: in-flight response ----------------------------------
      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          vld_p1 <= 1'b0;
          err_p1 <= 1'b0;
          rd_p1  <= 1'b0;
        end else begin
          vld_p1 <= hit_p0;
          err_p1 <= miss_p0;
          rd_p1  <= rd_p0;
        end
      end

      always_ff @(posedge i_clk) begin
        if (rd_p0)
          data_p1 <= mem[idx_p0];
      end

      // ---- stage p2: response registers ----------------------------------
      // A response still in p1 is dropped if the master releases cyc, so
      // nothing of an abandoned cycle ever reaches the bus.
      always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
          ack_q  <= 1'b0;
          err_q  <= 1'b0;
          data_q <= '0;
        end else begin
          ack_q <= vld_p1 & wb.i_wb_cyc;
          err_q <= err_p1 & wb.i_wb_cyc;
          if (rd_p1 & wb.i_wb_cyc)
            data_q <= data_p1;
        end
      end

    end
  endgenerate

  assign wb.o_wb_stall = 1'b0;
  assign wb.o_wb_ack   = ack_q;
  assign wb.o_wb_err   = err_q;
  assign wb.o_wb_data  = data_q;

endmodule

// File: tb/tb_wb_bkram_responder.sv
// ----------------------------------------------------------------------------
// tb_wb_bkram_responder
//
// Drives identical request streams into two responders (EXTRA_LATENCY 0 and
// 1) and compares each against a transaction-level reference: a word array
// for memory and a queue of pending responses per latency, each tagged with
// the clock edge on which it must be visible.
// ----------------------------------------------------------------------------
module tb_wb_bkram_responder;

  localparam logic [29:0] BASE = 30'h4000000;
  localparam logic [29:0] MASK = 30'h4000000;

  typedef struct {
    int          due;
    bit          err;
    bit          rd;
    logic [31:0] data;
  } resp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        cyc = 1'b0;
  logic        stb = 1'b0;
  logic        we = 1'b0;
  logic [29:0] addr = '0;
  logic [31:0] wdat = '0;
  logic [3:0]  sel = '0;

  int vectors = 0;
  int miscompares = 0;
  int edges = 0;

  logic [31:0] mem_m [4096];
  resp_t       q0[$];
  resp_t       q1[$];
  logic [31:0] dm0 = '0;
  logic [31:0] dm1 = '0;

  always #5 clk = ~clk;

  wb_bkram_if #(.AW(30), .DW(32)) bus0 ();
  wb_bkram_if #(.AW(30), .DW(32)) bus1 ();

  assign bus0.i_wb_cyc  = cyc;
  assign bus0.i_wb_stb  = stb;
  assign bus0.i_wb_we   = we;
  assign bus0.i_wb_addr = addr;
  assign bus0.i_wb_data = wdat;
  assign bus0.i_wb_sel  = sel;
  assign bus1.i_wb_cyc  = cyc;
  assign bus1.i_wb_stb  = stb;
  assign bus1.i_wb_we   = we;
  assign bus1.i_wb_addr = addr;
  assign bus1.i_wb_data = wdat;
  assign bus1.i_wb_sel  = sel;

  wb_bkram_responder #(.EXTRA_LATENCY(0)) dut0 (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .wb        (bus0.slave)
  );

  wb_bkram_responder #(.EXTRA_LATENCY(1)) dut1 (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .wb        (bus1.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s @edge %0d: got %h expected %h", tag, edges, got, exp);
    end
  endtask

  task automatic check_outputs();
    resp_t r;
    logic  a0, e0, a1, e1;
    a0 = 1'b0; e0 = 1'b0; a1 = 1'b0; e1 = 1'b0;
    while (q0.size() > 0 && q0[0].due <= edges) begin
      r = q0.pop_front();
      if (r.err) e0 = 1'b1; else a0 = 1'b1;
      if (r.rd) dm0 = r.data;
    end
    while (q1.size() > 0 && q1[0].due <= edges) begin
      r = q1.pop_front();
      if (r.err) e1 = 1'b1; else a1 = 1'b1;
      if (r.rd) dm1 = r.data;
    end
    chk("stall0", {31'd0, bus0.o_wb_stall}, 32'd0);
    chk("ack0",   {31'd0, bus0.o_wb_ack},   {31'd0, a0});
    chk("err0",   {31'd0, bus0.o_wb_err},   {31'd0, e0});
    chk("data0",  bus0.o_wb_data,           dm0);
    chk("stall1", {31'd0, bus1.o_wb_stall}, 32'd0);
    chk("ack1",   {31'd0, bus1.o_wb_ack},   {31'd0, a1});
    chk("err1",   {31'd0, bus1.o_wb_err},   {31'd0, e1});
    chk("data1",  bus1.o_wb_data,           dm1);
  endtask

  // One bus cycle: drive inputs, update the reference, clock, check.
  task automatic step(input logic c, input logic s, input logic w,
                      input logic [29:0] a, input logic [31:0] d, input logic [3:0] sl);
    logic        inwin;
    logic [31:0] old;
    int          ix;
    cyc = c; stb = s; we = w; addr = a; wdat = d; sel = sl;
    // Dropping cyc abandons every response not already shown.
    if (!c) begin
      q0.delete();
      q1.delete();
    end
    if (c && s && rst_n) begin
      inwin = ((a & MASK) == BASE);
      ix    = int'(a[11:0]);
      old   = mem_m[ix];
      q0.push_back('{due: edges + 1, err: !inwin, rd: inwin && !w, data: old});
      q1.push_back('{due: edges + 2, err: !inwin, rd: inwin && !w, data: old});
      if (inwin && w) begin
        for (int b = 0; b < 4; b++)
          if (sl[b]) mem_m[ix][b*8 +: 8] = d[b*8 +: 8];
      end
    end
    @(posedge clk);
    edges++;
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 30'd0, 32'd0, 4'd0);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_ack0"},  {31'd0, bus0.o_wb_ack}, 32'd0);
    chk({tag, "_err0"},  {31'd0, bus0.o_wb_err}, 32'd0);
    chk({tag, "_data0"}, bus0.o_wb_data,         32'd0);
    chk({tag, "_ack1"},  {31'd0, bus1.o_wb_ack}, 32'd0);
    chk({tag, "_err1"},  {31'd0, bus1.o_wb_err}, 32'd0);
    chk({tag, "_data1"}, bus1.o_wb_data,         32'd0);
  endtask

  task automatic random_run(input int n);
    logic        c, s, w, inw;
    logic [29:0] a;
    for (int i = 0; i < n; i++) begin
      c   = ($urandom_range(0, 9) != 0);
      s   = ($urandom_range(0, 3) != 0);
      w   = 1'($urandom_range(0, 1));
      inw = ($urandom_range(0, 4) != 0);
      a   = {3'($urandom), inw, 14'($urandom), 8'h00, 4'($urandom)};
      step(c, s, w, a, $urandom, 4'($urandom));
    end
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem_m[i] = '0;

    // Reset state
    #1 rst_n = 1'b0;
    #1 check_zero("reset");
    @(negedge clk);
    check_zero("reset_hold");
    rst_n = 1'b1;

    // Give every index used by random traffic a known value
    for (int i = 0; i < 16; i++)
      step(1'b1, 1'b1, 1'b1, BASE | 30'(i), $urandom, 4'hF);

    // Single write then read-back
    step(1'b1, 1'b1, 1'b1, 30'h4000010, 32'hDEADBEEF, 4'hF);
    step(1'b1, 1'b1, 1'b0, 30'h4000010, 32'd0, 4'h0);
    chk("rd_deadbeef", bus0.o_wb_data, 32'hDEADBEEF);
    idle();

    // Partial byte-lane write
    step(1'b1, 1'b1, 1'b1, 30'h4000020, 32'h11223344, 4'hF);
    step(1'b1, 1'b1, 1'b1, 30'h4000020, 32'hAABBCCDD, 4'b0101);
    step(1'b1, 1'b1, 1'b0, 30'h4000020, 32'd0, 4'h0);
    chk("rd_bytelane", bus0.o_wb_data, 32'h11BB33DD);
    idle();

    // Four back-to-back reads (both latencies stream)
    for (int i = 0; i < 4; i++)
      step(1'b1, 1'b1, 1'b0, BASE | 30'(i), 32'd0, 4'h0);
    step(1'b1, 1'b0, 1'b0, 30'd0, 32'd0, 4'h0);
    step(1'b1, 1'b0, 1'b0, 30'd0, 32'd0, 4'h0);
    idle();

    // Out-of-window read
    step(1'b1, 1'b1, 1'b0, 30'h0000010, 32'd0, 4'h0);
    chk("oow_err", {31'd0, bus0.o_wb_err}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 30'd0, 32'd0, 4'h0);
    idle();

    // Read then immediate cyc drop: slow responder must stay silent
    step(1'b1, 1'b1, 1'b0, BASE | 30'd5, 32'd0, 4'h0);
    idle();
    idle();

    // stb without cyc is ignored
    step(1'b0, 1'b1, 1'b1, BASE | 30'd6, 32'h55555555, 4'hF);
    step(1'b1, 1'b1, 1'b0, BASE | 30'd6, 32'd0, 4'h0);
    step(1'b1, 1'b0, 1'b0, 30'd0, 32'd0, 4'h0);
    idle();

    random_run(300);
    idle();

    // Reset with two reads in flight
    step(1'b1, 1'b1, 1'b0, BASE | 30'd3, 32'd0, 4'h0);
    step(1'b1, 1'b1, 1'b0, BASE | 30'd4, 32'd0, 4'h0);
    #1 rst_n = 1'b0;
    #1 check_zero("midrst");
    q0.delete();
    q1.delete();
    dm0 = '0;
    dm1 = '0;
    step(1'b1, 1'b1, 1'b1, BASE | 30'd3, 32'hBAD0BAD0, 4'hF);
    idle();
    rst_n = 1'b1;
    idle();
    idle();
    step(1'b1, 1'b1, 1'b0, BASE | 30'd3, 32'd0, 4'h0);
    step(1'b1, 1'b0, 1'b0, 30'd0, 32'd0, 4'h0);
    idle();

    random_run(200);
    idle();
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
